// File: rtl/display_sched_pkg.sv
// Shared constants and state type for the display digit scheduler.
// Six 4-bit digits, 3-bit digit/requester indices, 16-bit watchdog.
package display_sched_pkg;

    localparam int N_DIGITS = 6;
    localparam int DIGIT_W  = 4;
    localparam int IDX_W    = 3;
    localparam int WDOG_W   = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    // Next requester after id, wrapping at n.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] id, input int n);
        int nxt;
        nxt = int'(id) + 1;
        if (nxt >= n) begin
            nxt = 0;
        end
        return IDX_W'(nxt);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: picks the first set request at or after
// ptr, wrapping modulo N_REQ.
module rr_arbiter
    import display_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             found
);

    int best_dist;

    // Distance walked from ptr to reach requester i, going upward with wrap.
    function automatic int rot_dist(input int i, input logic [IDX_W-1:0] p);
        return (i - int'(p) + N_REQ) % N_REQ;
    endfunction

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        best_dist = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (rot_dist(i, ptr) < best_dist)) begin
                best_dist = rot_dist(i, ptr);
                grant_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates burst writes from several requesters into the six display digit
// registers, holding each grant until the last beat or a watchdog expiry.
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_last,
    input  logic [N_REQ*IDX_W-1:0]       req_digit,
    input  logic [N_REQ*DIGIT_W-1:0]     req_value,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_DIGITS*DIGIT_W-1:0]  digit_out,
    output logic                         grant_valid,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         bad_index,
    output logic                         timeout_evt
);

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

    sched_state_t                   state_q, state_d;
    logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]               grant_id_q, grant_id_d;
    logic                           grant_valid_q, grant_valid_d;
    logic [WDOG_W-1:0]              wdog_q, wdog_d;
    logic [N_DIGITS*DIGIT_W-1:0]    digits_q, digits_d;
    logic                           bad_index_q, bad_index_d;
    logic                           timeout_evt_q, timeout_evt_d;

    logic [IDX_W-1:0]               arb_idx;
    logic                           arb_found;
    logic                           sel_valid;
    logic                           sel_last;
    logic [IDX_W-1:0]               sel_digit;
    logic [DIGIT_W-1:0]             sel_value;
    logic                           accept;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant_idx (arb_idx),
        .found     (arb_found)
    );

    // Ready comes only from registered grant state, never from req_valid.
    always_comb begin
        req_ready = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_digit = '0;
        sel_value = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_q == IDX_W'(i)) begin
                req_ready[i] = (state_q == GRANT);
                sel_valid    = req_valid[i];
                sel_last     = req_last[i];
                sel_digit    = req_digit[i*IDX_W +: IDX_W];
                sel_value    = req_value[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign accept = (state_q == GRANT) && sel_valid;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        wdog_d        = wdog_q;
        bad_index_d   = 1'b0;
        timeout_evt_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d       = GRANT;
                    grant_id_d    = arb_idx;
                    grant_valid_d = 1'b1;
                    wdog_d        = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    wdog_d      = '0;
                    bad_index_d = (sel_digit >= IDX_W'(N_DIGITS));
                    if (sel_last) begin
                        state_d       = IDLE;
                        grant_valid_d = 1'b0;
                        grant_id_d    = '0;
                        rr_ptr_d      = wrap_inc(grant_id_q, N_REQ);
                    end
                end else if (wdog_q == WDOG_LIMIT) begin
                    // Stalled owner loses the grant; its written digits stay.
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                    rr_ptr_d      = wrap_inc(grant_id_q, N_REQ);
                    wdog_d        = '0;
                    timeout_evt_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        digits_d = digits_q;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (accept && (sel_digit == IDX_W'(d))) begin
                digits_d[d*DIGIT_W +: DIGIT_W] = sel_value;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            wdog_q        <= '0;
            digits_q      <= '0;
            bad_index_q   <= 1'b0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            wdog_q        <= wdog_d;
            digits_q      <= digits_d;
            bad_index_q   <= bad_index_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign digit_out   = digits_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign bad_index   = bad_index_q;
    assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: a behavioural model compared every
// cycle, plus directed bursts with hand-computed expectations.
module tb_display_scheduler;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 4;

    logic                 clk;
    logic                 reset;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ*3-1:0]   req_digit;
    logic [N_REQ*4-1:0]   req_value;
    logic [N_REQ-1:0]     req_ready;
    logic [23:0]          digit_out;
    logic                 grant_valid;
    logic [2:0]           grant_id;
    logic                 bad_index;
    logic                 timeout_evt;

    display_scheduler #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_digit   (req_digit),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .digit_out   (digit_out),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .bad_index   (bad_index),
        .timeout_evt (timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: who owns the display, pointer, idle count, digit array.
    logic m_granted;
    int   m_owner;
    int   m_ptr;
    int   m_idle;
    int   m_digits[6];
    logic m_bad;
    logic m_tmo;

    function automatic int first_from(input logic [N_REQ-1:0] v, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return 0;
    endfunction

    function automatic int digit_of(input int i);
        return int'(req_digit[3*i +: 3]);
    endfunction

    function automatic int value_of(input int i);
        return int'(req_value[4*i +: 4]);
    endfunction

    function automatic logic [23:0] pack_digits();
        logic [23:0] r;
        for (int d = 0; d < 6; d++) r[4*d +: 4] = 4'(m_digits[d]);
        return r;
    endfunction

    function automatic logic [N_REQ-1:0] expected_ready();
        logic [N_REQ-1:0] r;
        r = '0;
        if (m_granted) r[m_owner] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_granted <= 1'b0;
            m_owner   <= 0;
            m_ptr     <= 0;
            m_idle    <= 0;
            m_bad     <= 1'b0;
            m_tmo     <= 1'b0;
            for (int d = 0; d < 6; d++) m_digits[d] <= 0;
        end else begin
            m_bad <= 1'b0;
            m_tmo <= 1'b0;
            if (!m_granted) begin
                if (req_valid != '0) begin
                    m_granted <= 1'b1;
                    m_owner   <= first_from(req_valid, m_ptr);
                    m_idle    <= 0;
                end
            end else if (req_valid[m_owner]) begin
                if (digit_of(m_owner) < 6) m_digits[digit_of(m_owner)] <= value_of(m_owner);
                else m_bad <= 1'b1;
                m_idle <= 0;
                if (req_last[m_owner]) begin
                    m_granted <= 1'b0;
                    m_owner   <= 0;
                    m_ptr     <= (m_owner + 1) % N_REQ;
                end
            end else if (m_idle + 1 >= TIMEOUT) begin
                m_granted <= 1'b0;
                m_owner   <= 0;
                m_ptr     <= (m_owner + 1) % N_REQ;
                m_idle    <= 0;
                m_tmo     <= 1'b1;
            end else begin
                m_idle <= m_idle + 1;
            end
        end
    end

    // Per-cycle compare against the model, plus event statistics for directed checks.
    logic             check_en = 1'b0;
    logic [N_REQ-1:0] ready_neg = '0;
    logic             prev_gv = 1'b0;
    int               ready_count[N_REQ] = '{default: 0};
    int               acc_count[N_REQ] = '{default: 0};
    int               grants[$];
    int               gaps[$];
    int               low_run = 0;
    int               bad_count = 0;
    int               tmo_count = 0;

    always @(negedge clk) begin
        if (check_en) begin
            check_output("digit_out",   32'(digit_out),   32'(pack_digits()));
            check_output("grant_valid", 32'(grant_valid), 32'(m_granted));
            check_output("grant_id",    32'(grant_id),    32'(m_owner));
            check_output("req_ready",   32'(req_ready),   32'(expected_ready()));
            check_output("bad_index",   32'(bad_index),   32'(m_bad));
            check_output("timeout_evt", 32'(timeout_evt), 32'(m_tmo));
        end
        ready_neg <= req_ready;
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i]) ready_count[i] <= ready_count[i] + 1;
                if (req_ready[i] && req_valid[i]) acc_count[i] <= acc_count[i] + 1;
            end
            if (grant_valid && !prev_gv) begin
                grants.push_back(int'(grant_id));
                gaps.push_back(low_run);
            end
            low_run   <= grant_valid ? 0 : low_run + 1;
            bad_count <= bad_count + int'(bad_index);
            tmo_count <= tmo_count + int'(timeout_evt);
        end
        prev_gv <= grant_valid;
    end

    function automatic int grant_at(input int idx);
        return (idx < grants.size()) ? grants[idx] : -1;
    endfunction

    function automatic int gap_at(input int idx);
        return (idx < gaps.size()) ? gaps[idx] : -1;
    endfunction

    task automatic set_beat(input int i, input logic [2:0] dig, input logic [3:0] val, input logic last);
        req_valid[i]         = 1'b1;
        req_last[i]          = last;
        req_digit[3*i +: 3]  = dig;
        req_value[4*i +: 4]  = val;
    endtask

    // Presents n beats from requester i, advancing on each accepted beat.
    task automatic apply_stimulus(input int i, input int n, input logic [23:0] digs,
                                  input logic [31:0] vals, input logic [7:0] lasts);
        int k;
        int waited;
        k = 0;
        waited = 0;
        @(posedge clk);
        #1;
        set_beat(i, digs[2:0], vals[3:0], lasts[0]);
        while (k < n) begin
            @(posedge clk);
            if (!reset) break;
            if (ready_neg[i]) begin
                k++;
                waited = 0;
                #1;
                if (k < n) set_beat(i, digs[3*k +: 3], vals[4*k +: 4], lasts[k]);
            end else begin
                waited++;
                if (waited > 60) begin
                    #1;
                    check_output("burst_stall", 32'(k), 32'(n));
                    break;
                end
            end
        end
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
    endtask

    int base_g, base_gap, base_rc, base_bad, base_tmo, base_acc, w;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_digit = '0;
        req_value = '0;
        #2 reset = 1'b0;
        #2;
        check_en = 1'b1;
        check_output("rst_digit_out",   32'(digit_out),   32'h0);
        check_output("rst_grant_valid", 32'(grant_valid), 32'h0);
        check_output("rst_grant_id",    32'(grant_id),    32'h0);
        check_output("rst_req_ready",   32'(req_ready),   32'h0);
        check_output("rst_bad_index",   32'(bad_index),   32'h0);
        check_output("rst_timeout_evt", 32'(timeout_evt), 32'h0);
        #23 reset = 1'b1;

        // Single beat from req0: digit 2 <- 0xA
        base_g  = grants.size();
        base_rc = ready_count[0];
        apply_stimulus(0, 1, 24'(3'd2), 32'(4'hA), 8'h01);
        @(negedge clk); #1;
        check_output("t1_digit_out",   32'(digit_out), 32'h000A00);
        check_output("t1_ready_cycles", 32'(ready_count[0] - base_rc), 32'd1);
        check_output("t1_grant_id",    32'(grant_at(base_g)), 32'd0);

        // req1 and req3 each stream two 3-beat bursts with valid held high
        base_g   = grants.size();
        base_gap = gaps.size();
        fork
            apply_stimulus(1, 6, 24'({3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0}),
                           32'({4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1}), 8'b0010_0100);
            apply_stimulus(3, 6, 24'({3'd5, 3'd4, 3'd3, 3'd5, 3'd4, 3'd3}),
                           32'({4'hC, 4'hB, 4'hA, 4'h9, 4'h8, 4'h7}), 8'b0010_0100);
        join
        @(negedge clk); #1;
        check_output("t2_grant_count", 32'(grants.size() - base_g), 32'd4);
        check_output("t2_grant0", 32'(grant_at(base_g)),     32'd1);
        check_output("t2_grant1", 32'(grant_at(base_g + 1)), 32'd3);
        check_output("t2_grant2", 32'(grant_at(base_g + 2)), 32'd1);
        check_output("t2_grant3", 32'(grant_at(base_g + 3)), 32'd3);
        check_output("t2_gap1", 32'(gap_at(base_gap + 1)), 32'd1);
        check_output("t2_gap2", 32'(gap_at(base_gap + 2)), 32'd1);
        check_output("t2_gap3", 32'(gap_at(base_gap + 3)), 32'd1);
        check_output("t2_digit_out", 32'(digit_out), 32'hCBA654);

        // req2 writes 5..0 into digits 0..5 in one 6-beat burst
        base_g  = grants.size();
        base_rc = ready_count[2];
        apply_stimulus(2, 6, 24'({3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}),
                       32'({4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5}), 8'b0010_0000);
        @(negedge clk); #1;
        check_output("t3_digit_out",    32'(digit_out), 32'h012345);
        check_output("t3_ready_cycles", 32'(ready_count[2] - base_rc), 32'd6);
        check_output("t3_grant_count",  32'(grants.size() - base_g), 32'd1);
        check_output("t3_grant_id",     32'(grant_at(base_g)), 32'd2);

        // req0: out-of-range index 7, then digit 1 <- 9 with last
        base_bad = bad_count;
        apply_stimulus(0, 2, 24'({3'd1, 3'd7}), 32'({4'h9, 4'hF}), 8'b0000_0010);
        @(negedge clk); #1;
        check_output("t4_bad_pulses", 32'(bad_count - base_bad), 32'd1);
        check_output("t4_digit_out",  32'(digit_out), 32'h012395);

        // req1 stalls after one non-last beat; req2 waits behind it
        base_g   = grants.size();
        base_tmo = tmo_count;
        base_rc  = ready_count[1];
        fork
            apply_stimulus(1, 1, 24'(3'd3), 32'(4'h7), 8'h00);
            apply_stimulus(2, 1, 24'(3'd4), 32'(4'hC), 8'h01);
        join
        @(negedge clk); #1;
        check_output("t5_timeout_pulses", 32'(tmo_count - base_tmo), 32'd1);
        check_output("t5_req1_ready_cycles", 32'(ready_count[1] - base_rc), 32'd5);
        check_output("t5_grant0", 32'(grant_at(base_g)),     32'd1);
        check_output("t5_grant1", 32'(grant_at(base_g + 1)), 32'd2);
        check_output("t5_digit_out", 32'(digit_out), 32'h0C7395);

        // Reset lands after req0 has delivered two of four beats
        base_acc = acc_count[0];
        fork
            apply_stimulus(0, 4, 24'({3'd3, 3'd2, 3'd1, 3'd0}),
                           32'({4'h4, 4'h3, 4'h2, 4'h1}), 8'b0000_1000);
            begin
                w = 0;
                while (acc_count[0] < base_acc + 2) begin
                    @(negedge clk); #1;
                    w++;
                    if (w > 60) begin
                        check_output("t6_wait_beats", 32'(acc_count[0] - base_acc), 32'd2);
                        break;
                    end
                end
                @(posedge clk);
                #3 reset = 1'b0;
                #1;
                check_output("t6_digit_out",    32'(digit_out),   32'h0);
                check_output("t6_grant_valid",  32'(grant_valid), 32'h0);
                check_output("t6_grant_id",     32'(grant_id),    32'h0);
                check_output("t6_req_ready",    32'(req_ready),   32'h0);
                check_output("t6_bad_index",    32'(bad_index),   32'h0);
                check_output("t6_timeout_evt",  32'(timeout_evt), 32'h0);
                #17 reset = 1'b1;
            end
        join

        base_g = grants.size();
        fork
            apply_stimulus(0, 1, 24'(3'd0), 32'(4'h6), 8'h01);
            apply_stimulus(3, 1, 24'(3'd5), 32'(4'hE), 8'h01);
        join
        @(negedge clk); #1;
        check_output("t6_first_grant",  32'(grant_at(base_g)),     32'd0);
        check_output("t6_second_grant", 32'(grant_at(base_g + 1)), 32'd3);
        check_output("t6_final_digits", 32'(digit_out), 32'hE00006);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
